// File: rtl/bsa_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package bsa_pkg;

  localparam int BSA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bsa_state_e;

  // Counter must reach WIDTH itself (one past the last bit index).
  function automatic int bsa_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bsa_bit_slice.sv
// One-bit full adder; the only arithmetic in the serial datapath.
module bsa_bit_slice (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | ((a ^ b) & c);

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice, one bit per clock, LSB first.
// Optional macro BSA_SIGNED_OVF_EN adds a two's-complement overflow output ovf.
module bit_serial_adder_ctrl
  import bsa_pkg::*;
#(
  parameter int WIDTH = BSA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef BSA_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = bsa_cnt_w(WIDTH);

  bsa_state_e       state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             load, step, last;
  logic             slice_s, slice_co;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  bsa_bit_slice u_slice (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .c  (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // sum_sh is not cleared on load: the previous result stays visible in IDLE
  // and is naturally shifted out while the next operation runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (step) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      sum_sh <= {slice_s, sum_sh[WIDTH-1:1]};
      carry  <= slice_co;
      cnt    <= cnt + CNT_W'(1);
    end
  end

`ifdef BSA_SIGNED_OVF_EN
  logic ovf_q;

  // On the last bit, carry is the carry into the MSB and slice_co is cout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ovf_q <= 1'b0;
    else if (step && last) ovf_q <= carry ^ slice_co;
  end

  assign ovf = ovf_q;
`endif

  assign sum  = sum_sh;
  assign cout = carry;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Scoreboard bench for bit_serial_adder_ctrl (WIDTH=8); checks ovf when BSA_SIGNED_OVF_EN is defined.
module tb_bit_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W:0] res;
    logic       ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef BSA_SIGNED_OVF_EN
  logic         ovf;
`endif

  int   errors = 0;
  int   checks = 0;
  int   in_hs = 0;
  int   out_hs = 0;
  exp_t q[$];

  bit_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef BSA_SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready)   in_hs  <= in_hs + 1;
      if (out_valid && out_ready) out_hs <= out_hs + 1;
    end
  end

  // Drive one operation until accepted; push its expected result.
  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
    int   n = 0;
    exp_t e;
    @(posedge clk); #1;
    a = av; b = bv; cin = ci; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~av; b = ~bv; cin = ~ci;
    e.res = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
    e.ovf = (av[W-1] == bv[W-1]) && (e.res[W-1] != av[W-1]);
    q.push_back(e);
  endtask

  // Wait for a result (optionally with random out_ready noise), hold it for
  // 'stall' cycles under backpressure, then handshake and compare.
  task automatic collect(input int stall, input bit noise);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      if (noise) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL result_timeout out_valid=%0b required=1", out_valid);
      out_ready = 1'b0;
      return;
    end
    out_ready = (stall == 0);
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got=%h", {cout, sum});
      return;
    end
    e = q.pop_front();
    if ({cout, sum} !== e.res) begin
      errors++;
      $display("FAIL result {cout,sum}=%h required=%h", {cout, sum}, e.res);
    end
`ifdef BSA_SIGNED_OVF_EN
    checks++;
    if (ovf !== e.ovf) begin
      errors++;
      $display("FAIL ovf got=%0b required=%0b", ovf, e.ovf);
    end
`endif
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== e.res) begin
        errors++;
        $display("FAIL stall_hold out_valid=%0b in_ready=%0b {cout,sum}=%h required 1/0/%h",
                 out_valid, in_ready, {cout, sum}, e.res);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset in_ready=%0b out_valid=%0b busy=%0b sum=%h cout=%0b required 1/0/0/00/0",
               in_ready, out_valid, busy, sum, cout);
    end
`ifdef BSA_SIGNED_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got=%0b required=0", ovf);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    accept(8'h5A, 8'h3C, 1'b0);
    // Accepted at edge T; negedges 1..W follow edges T..T+W-1 (still RUN).
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL run_cycle%0d out_valid=%0b in_ready=%0b busy=%0b required 0/0/1",
                 i, out_valid, in_ready, busy);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency out_valid=%0b required=1 after %0d edges", out_valid, W);
    end
    collect(0, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 8'h96) begin
      errors++;
      $display("FAIL idle_hold out_valid=%0b in_ready=%0b sum=%h required 0/1/96",
               out_valid, in_ready, sum);
    end
  endtask

  task automatic test_carry();
    accept(8'hFF, 8'h01, 1'b0);
    collect(0, 1'b0);
    accept(8'hFF, 8'h00, 1'b1);
    collect(0, 1'b0);
  endtask

  task automatic test_backpressure();
    int hs0;
    accept(8'h12, 8'h34, 1'b0);
    hs0 = in_hs;
    a = 8'hFF; b = 8'hFF;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          in_valid = (i % 3 == 0);
        end
        in_valid = 1'b0;
      end
      collect(20, 1'b0);
    join
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_hs !== hs0) begin
      errors++;
      $display("FAIL backpressure_end out_valid=%0b extra_accepts=%0d required 0/0",
               out_valid, in_hs - hs0);
    end
  endtask

  task automatic test_abort();
    accept(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(q.pop_back());
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort out_valid=%0b in_ready=%0b busy=%0b required 0/1/0",
               out_valid, in_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    accept(8'h01, 8'h01, 1'b0);
    collect(0, 1'b0);
  endtask

`ifdef BSA_SIGNED_OVF_EN
  task automatic test_ovf();
    accept(8'h7F, 8'h01, 1'b0);
    collect(0, 1'b0);
    accept(8'hFF, 8'hFF, 1'b0);
    collect(0, 1'b0);
  endtask
`endif

  task automatic test_random();
    int i0, o0;
    logic [W-1:0] av, bv;
    i0 = in_hs;
    o0 = out_hs;
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      av = W'($urandom);
      bv = W'($urandom);
      accept(av, bv, 1'($urandom_range(0, 1)));
      collect($urandom_range(0, 4), 1'b1);
    end
    @(negedge clk);
    checks++;
    if (in_hs - i0 !== 1000 || out_hs - o0 !== 1000 || q.size() != 0) begin
      errors++;
      $display("FAIL handshake_count in=%0d out=%0d left=%0d required 1000/1000/0",
               in_hs - i0, out_hs - o0, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_abort();
`ifdef BSA_SIGNED_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
